// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU front end: operation codes, opcodes,
// the issued request format and the issue-queue state encoding.
package alu_pkg;

    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b0001;
    localparam logic [3:0] SLL  = 4'b0010;
    localparam logic [3:0] SLT  = 4'b0011;
    localparam logic [3:0] SLTU = 4'b0100;
    localparam logic [3:0] SRL  = 4'b0101;
    localparam logic [3:0] SRA  = 4'b0110;
    localparam logic [3:0] AND  = 4'b1011;
    localparam logic [3:0] OR   = 4'b1100;
    localparam logic [3:0] XOR  = 4'b1101;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    typedef struct packed {
        logic [31:0] A;
        logic [31:0] B;
        logic [3:0]  operation;
        logic [4:0]  rd;
    } alu_req_t;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } q_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I OP/OP-IMM decoder: produces the ALU request and flags
// encodings the ALU cannot execute.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output alu_req_t    req,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       alt;
    logic       is_shift;
    logic [3:0] base_op;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign alt      = (funct7 == 7'b0100000);
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        base_op = ADD;
        case (funct3)
            3'b000: base_op = ADD;
            3'b001: base_op = SLL;
            3'b010: base_op = SLT;
            3'b011: base_op = SLTU;
            3'b100: base_op = XOR;
            3'b101: base_op = alt ? SRA : SRL;
            3'b110: base_op = OR;
            3'b111: base_op = AND;
            default: base_op = ADD;
        endcase
    end

    always_comb begin
        req.A         = rs1_data;
        req.B         = rs2_data;
        req.operation = base_op;
        req.rd        = instr[11:7];
        illegal       = 1'b0;
        case (opcode)
            OPC_OP: begin
                if ((funct3 == 3'b000) && alt) req.operation = SUB;
                illegal = !((funct7 == 7'b0000000) ||
                            (alt && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OPC_OPIMM: begin
                // ADDI never becomes SUB: base_op already maps 000 to ADD.
                if (is_shift) begin
                    req.B   = {27'b0, instr[24:20]};
                    illegal = !((funct7 == 7'b0000000) || (alt && (funct3 == 3'b101)));
                end else begin
                    req.B   = {{20{instr[31]}}, instr[31:20]};
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Issue stage in front of the ALU: decodes accepted instructions into a
// 2-entry FIFO and counts illegal instructions that are consumed but dropped.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      A,
    output logic [31:0]      B,
    output logic [3:0]       operation,
    output logic [4:0]       rd,
    output logic             IllegalPulse,
    output logic [CNT_W-1:0] IllegalCount
);

    alu_req_t   dec_req;
    logic       dec_illegal;
    q_state_e   state_q, state_d;
    alu_req_t   head_q, head_d;
    alu_req_t   tail_q, tail_d;
    logic       pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0] fill;
    logic       accept, issue, push;

    alu_op_decode u_decode (
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .req      (dec_req),
        .illegal  (dec_illegal)
    );

    always_comb begin
        fill = 2'd0;
        case (state_q)
            Q_EMPTY: fill = 2'd0;
            Q_ONE:   fill = 2'd1;
            Q_FULL:  fill = 2'd2;
            default: fill = 2'd0;
        endcase
    end

    // Both handshake outputs depend on registered state only.
    assign in_ready  = ({30'b0, fill} < DEPTH);
    assign out_valid = (state_q != Q_EMPTY);
    assign accept    = in_valid & in_ready;
    assign issue     = out_valid & out_ready;
    assign push      = accept & ~dec_illegal;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            Q_EMPTY: begin
                if (push) begin
                    head_d  = dec_req;
                    state_d = Q_ONE;
                end
            end
            Q_ONE: begin
                if (push && issue) begin
                    head_d = dec_req;
                end else if (push) begin
                    tail_d  = dec_req;
                    state_d = Q_FULL;
                end else if (issue) begin
                    state_d = Q_EMPTY;
                end
            end
            Q_FULL: begin
                if (issue) begin
                    head_d  = tail_q;
                    state_d = Q_ONE;
                end
            end
            default: state_d = Q_EMPTY;
        endcase
    end

    always_comb begin
        pulse_d = accept & dec_illegal;
        cnt_d   = cnt_q;
        if (pulse_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= Q_EMPTY;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    // Payload storage carries no reset; outputs are masked while empty.
    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    assign A            = out_valid ? head_q.A         : 32'b0;
    assign B            = out_valid ? head_q.B         : 32'b0;
    assign operation    = out_valid ? head_q.operation : 4'b0;
    assign rd           = out_valid ? head_q.rd        : 5'b0;
    assign IllegalPulse = pulse_q;
    assign IllegalCount = cnt_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed plus randomized bench for alu_op_issuer against a queue-based
// reference model of the decode rules and FIFO behaviour.
module tb_alu_op_issuer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'b0;
    logic [31:0] rs1_data = 32'b0;
    logic [31:0] rs2_data = 32'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  operation;
    logic [4:0]  rd;
    logic        IllegalPulse;
    logic [7:0]  IllegalCount;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          legal;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];
    int   m_cnt = 0;
    bit   m_pulse = 0;

    alu_op_issuer #(.DEPTH(2), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .A            (A),
        .B            (B),
        .operation    (operation),
        .rd           (rd),
        .IllegalPulse (IllegalPulse),
        .IllegalCount (IllegalCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] plain_op(input logic [2:0] f3);
        case (f3)
            3'd0: return 4'b0000;
            3'd1: return 4'b0010;
            3'd2: return 4'b0011;
            3'd3: return 4'b0100;
            3'd4: return 4'b1101;
            3'd5: return 4'b0101;
            3'd6: return 4'b1100;
            default: return 4'b1011;
        endcase
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        e.legal = 0; e.a = r1; e.b = 32'b0; e.op = 4'b0; e.rd = ins[11:7];
        if (ins[6:0] == 7'h33) begin
            e.b = r2;
            if (f7 == 7'h00) begin e.legal = 1; e.op = plain_op(f3); end
            else if (f7 == 7'h20 && f3 == 3'd0) begin e.legal = 1; e.op = 4'b0001; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin e.legal = 1; e.op = 4'b0110; end
        end else if (ins[6:0] == 7'h13) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                e.b = {27'b0, ins[24:20]};
                if (f7 == 7'h00) begin e.legal = 1; e.op = plain_op(f3); end
                else if (f7 == 7'h20 && f3 == 3'd5) begin e.legal = 1; e.op = 4'b0110; end
            end else begin
                e.b = {{20{ins[31]}}, ins[31:20]};
                e.legal = 1;
                e.op = plain_op(f3);
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_instr(input bit allow_illegal);
        logic [31:0] w = $urandom();
        int k = allow_illegal ? $urandom_range(0, 4) : $urandom_range(0, 1);
        case (k)
            0: begin
                w[6:0] = 7'h33;
                w[31:25] = (w[30] && (w[14:12] == 3'd0 || w[14:12] == 3'd5)) ? 7'h20 : 7'h00;
            end
            1: begin
                w[6:0] = 7'h13;
                if (w[14:12] == 3'd1) w[31:25] = 7'h00;
                if (w[14:12] == 3'd5) w[31:25] = w[30] ? 7'h20 : 7'h00;
            end
            2: w[6:0] = 7'h33;
            3: w[6:0] = 7'h13;
            default: ;
        endcase
        return w;
    endfunction

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            chk("A", A, q[0].a);
            chk("B", B, q[0].b);
            chk("operation", 32'(operation), 32'(q[0].op));
            chk("rd", 32'(rd), 32'(q[0].rd));
        end else begin
            chk("A_empty", A, 32'b0);
            chk("B_empty", B, 32'b0);
            chk("op_empty", 32'(operation), 32'b0);
            chk("rd_empty", 32'(rd), 32'b0);
        end
        chk("IllegalPulse", 32'(IllegalPulse), 32'(m_pulse));
        chk("IllegalCount", 32'(IllegalCount), 32'(m_cnt));
    endtask

    task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input bit ordy);
        exp_t e;
        bit acc, iss;
        in_valid = v; instr = ins; rs1_data = r1; rs2_data = r2; out_ready = ordy;
        e = ref_decode(ins, r1, r2);
        acc = v && (q.size() < 2);
        iss = ordy && (q.size() > 0);
        @(posedge clk); #1;
        if (iss) q.delete(0);
        if (acc && e.legal) q.push_back(e);
        m_pulse = acc && !e.legal;
        if (m_pulse && m_cnt < 255) m_cnt++;
        check_all();
    endtask

    task automatic do_reset(input bit v, input logic [31:0] ins);
        reset = 1'b1; in_valid = v; instr = ins; out_ready = 1'b0;
        @(posedge clk); #1;
        q.delete(); m_cnt = 0; m_pulse = 0;
        reset = 1'b0;
        check_all();
    endtask

    initial begin
        do_reset(1'b0, 32'b0);

        // and x3,x1,x2
        cycle(1, 32'h0020F1B3, 32'hF0F0F0F0, 32'hFF00FF00, 0);
        chk("and_valid", 32'(out_valid), 32'd1);
        chk("and_op", 32'(operation), 32'b1011);
        chk("and_A", A, 32'hF0F0F0F0);
        chk("and_B", B, 32'hFF00FF00);
        chk("and_rd", 32'(rd), 32'd3);
        // addi x5,x1,-1 while the AND issues
        cycle(1, 32'hFFF08293, 32'h12345678, 32'h0, 1);
        chk("addi_op", 32'(operation), 32'b0000);
        chk("addi_B", B, 32'hFFFFFFFF);
        chk("addi_rd", 32'(rd), 32'd5);
        // srai x6,x1,4
        cycle(1, 32'h4040D313, 32'h80000000, 32'h0, 1);
        chk("srai_op", 32'(operation), 32'b0110);
        chk("srai_B", B, 32'h00000004);
        cycle(0, 32'h0, 32'h0, 32'h0, 1);

        // Back-pressure: three back-to-back, only two accepted
        cycle(1, gen_instr(0), $urandom(), $urandom(), 0);
        cycle(1, gen_instr(0), $urandom(), $urandom(), 0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        cycle(1, gen_instr(0), $urandom(), $urandom(), 0);
        chk("full_hold_ready", 32'(in_ready), 32'd0);
        cycle(0, 32'h0, 32'h0, 32'h0, 1);
        chk("ready_after_issue", 32'(in_ready), 32'd1);
        cycle(0, 32'h0, 32'h0, 32'h0, 1);

        // Simultaneous accept and issue in ONE
        cycle(1, gen_instr(0), $urandom(), $urandom(), 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, gen_instr(0), $urandom(), $urandom(), 1);
            chk("flow_valid", 32'(out_valid), 32'd1);
        end
        cycle(0, 32'h0, 32'h0, 32'h0, 1);

        // ecall is consumed but dropped
        cycle(1, 32'h00000073, 32'h1, 32'h2, 0);
        chk("ecall_pulse", 32'(IllegalPulse), 32'd1);
        chk("ecall_count", 32'(IllegalCount), 32'd1);
        chk("ecall_noenq", 32'(out_valid), 32'd0);
        cycle(0, 32'h0, 32'h0, 32'h0, 0);
        chk("ecall_pulse_end", 32'(IllegalPulse), 32'd0);
        for (int i = 0; i < 300; i++) cycle(1, 32'h00000073, $urandom(), $urandom(), 0);
        chk("count_saturated", 32'(IllegalCount), 32'd255);

        // Randomized traffic
        do_reset(1'b0, 32'b0);
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, gen_instr(1), $urandom(), $urandom(),
                  $urandom_range(0, 2) != 0);

        // Reset while FULL with an instruction pending
        cycle(0, 32'h0, 32'h0, 32'h0, 1);
        cycle(0, 32'h0, 32'h0, 32'h0, 1);
        cycle(1, gen_instr(0), $urandom(), $urandom(), 0);
        cycle(1, gen_instr(0), $urandom(), $urandom(), 0);
        chk("prereset_full", 32'(in_ready), 32'd0);
        do_reset(1'b1, 32'h0020F1B3);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(IllegalCount), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
